fft_ctrl_sm_param: RTL and testbench

Parametrised control FSM for an in-place radix-2 DIT FFT of N = 2**LOG2N complex points.
- Loads samples into the working RAM in bit-reversed order.
- Sequences LOG2N stages of N/2 butterflies with correct per-stage addressing and twiddle indices.
- Delays write-back to match a pipelined butterfly, and drains the pipeline between stages.
- Streams results out under an out_stall handshake.
- Sits between the sample source and the shared RAM, twiddle ROM and butterfly datapath in fft_top.

---
 rtl/fft_ctrl_sm_param.sv | 213 +++++++++++++++++++++
 tb/tb_fft_ctrl_sm_param.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_ctrl_sm_param.sv
// Control sequencer for an in-place radix-2 DIT FFT: bit-reversed load, staged butterfly
// issue with a write-back delay line matching the butterfly pipeline, and stalled output.
module fft_ctrl_sm_param #(
  parameter int LOG2N  = 4,
  parameter int DW     = 16,
  parameter int BF_LAT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_push,
  input  logic [DW-1:0]      in_real,
  input  logic [DW-1:0]      in_imag,
  output logic               in_stall,
  output logic [LOG2N-1:0]   read_addr_1,
  output logic [LOG2N-1:0]   read_addr_2,
  output logic [LOG2N-2:0]   w_addr,
  output logic               bfly_valid,
  output logic [LOG2N-1:0]   write_addr_1,
  output logic [2*DW-1:0]    write_data_1,
  output logic               write_en_1,
  output logic [LOG2N-1:0]   write_addr_2,
  output logic               write_en_2,
  output logic               write_back,
  output logic               out_push,
  input  logic               out_stall,
  output logic               busy,
  output logic               done
);

  // state   | meaning
  // IDLE    | waiting for the first sample of a frame
  // LOAD    | writing samples at bit-reversed addresses
  // COMPUTE | issuing one butterfly per cycle for the current stage
  // DRAIN   | letting the butterfly pipeline empty before the next stage
  // OUTPUT  | streaming results in natural order under out_stall
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_DRAIN   = 3'd3,
    S_OUTPUT  = 3'd4
  } state_t;

  localparam int SW = $clog2(LOG2N);

  localparam logic [LOG2N-1:0] CNT_LAST   = '1;
  localparam logic [LOG2N-1:0] ONE        = LOG2N'(1);
  localparam logic [LOG2N-2:0] B_LAST     = '1;
  localparam logic [SW-1:0]    STAGE_LAST = SW'(LOG2N - 1);
  localparam logic [3:0]       DRAIN_INIT = 4'(BF_LAT - 1);

  state_t           state;
  logic [LOG2N-1:0] cnt;
  logic [SW-1:0]    stage;
  logic [LOG2N-2:0] bidx;
  logic [3:0]       drain_cnt;

  logic             dl_v  [BF_LAT];
  logic [LOG2N-1:0] dl_a1 [BF_LAT];
  logic [LOG2N-1:0] dl_a2 [BF_LAT];

  logic [LOG2N-1:0] cnt_rev;
  logic [LOG2N-1:0] b_ext;
  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] pos;
  logic [LOG2N-1:0] top;
  logic [SW-1:0]    w_shift;
  logic [LOG2N-2:0] w_idx;

  always_comb begin
    cnt_rev = '0;
    for (int i = 0; i < LOG2N; i++) cnt_rev[i] = cnt[LOG2N-1-i];
  end

  // Butterfly b of stage s sits in group b>>s; the group base is that index times 2*span.
  always_comb begin
    b_ext   = {1'b0, bidx};
    span    = ONE << stage;
    pos     = b_ext & (span - ONE);
    top     = ((b_ext >> stage) << stage) << 1;
    w_shift = STAGE_LAST - stage;
    w_idx   = (LOG2N-1)'(pos << w_shift);
  end

  always_comb begin
    in_stall     = 1'b0;
    read_addr_1  = '0;
    read_addr_2  = '0;
    w_addr       = '0;
    bfly_valid   = 1'b0;
    write_addr_1 = '0;
    write_data_1 = '0;
    write_en_1   = 1'b0;
    write_addr_2 = '0;
    write_en_2   = 1'b0;
    write_back   = 1'b0;
    out_push     = 1'b0;
    done         = 1'b0;
    busy         = (state != S_IDLE);
    unique case (state)
      S_IDLE, S_LOAD: begin
        write_en_1   = in_push;
        write_addr_1 = cnt_rev;
        write_data_1 = in_push ? {in_real, in_imag} : '0;
      end
      S_COMPUTE, S_DRAIN, S_OUTPUT: begin
        in_stall     = 1'b1;
        write_back   = 1'b1;
        write_en_1   = dl_v[BF_LAT-1];
        write_en_2   = dl_v[BF_LAT-1];
        write_addr_1 = dl_a1[BF_LAT-1];
        write_addr_2 = dl_a2[BF_LAT-1];
        if (state == S_COMPUTE) begin
          bfly_valid  = 1'b1;
          read_addr_1 = top | pos;
          read_addr_2 = top | pos | span;
          w_addr      = w_idx;
        end
        if (state == S_OUTPUT) begin
          read_addr_1 = cnt;
          out_push    = !out_stall;
          done        = !out_stall && (cnt == CNT_LAST);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      stage     <= '0;
      bidx      <= '0;
      drain_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_push) begin
            cnt   <= ONE;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_push) begin
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              stage <= '0;
              bidx  <= '0;
              state <= S_COMPUTE;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        S_COMPUTE: begin
          if (bidx == B_LAST) begin
            bidx      <= '0;
            drain_cnt <= DRAIN_INIT;
            state     <= S_DRAIN;
          end else begin
            bidx <= bidx + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 4'd0) begin
            if (stage == STAGE_LAST) begin
              cnt   <= '0;
              state <= S_OUTPUT;
            end else begin
              stage <= stage + SW'(1);
              state <= S_COMPUTE;
            end
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        S_OUTPUT: begin
          if (!out_stall) begin
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= S_IDLE;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Issued addresses reappear on the write ports BF_LAT cycles later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BF_LAT; i++) begin
        dl_v[i]  <= 1'b0;
        dl_a1[i] <= '0;
        dl_a2[i] <= '0;
      end
    end else begin
      dl_v[0]  <= bfly_valid;
      dl_a1[0] <= read_addr_1;
      dl_a2[0] <= read_addr_2;
      for (int i = 1; i < BF_LAT; i++) begin
        dl_v[i]  <= dl_v[i-1];
        dl_a1[i] <= dl_a1[i-1];
        dl_a2[i] <= dl_a2[i-1];
      end
    end
  end

endmodule

// File: tb/tb_fft_ctrl_sm_param.sv
// Scoreboard bench: a default (N=16, BF_LAT=2) and a small (N=8, BF_LAT=1) controller
// share stimulus; sel picks which one is driven and observed.
module tb_fft_ctrl_sm_param;

  logic        clk = 1'b0;
  logic        reset, in_push, out_stall, sel;
  logic [15:0] in_real, in_imag;

  logic        b_in_stall, b_bv, b_we1, b_we2, b_wb, b_op, b_busy, b_done;
  logic [3:0]  b_ra1, b_ra2, b_wa1, b_wa2;
  logic [2:0]  b_w;
  logic [31:0] b_wd1;

  logic        s_in_stall, s_bv, s_we1, s_we2, s_wb, s_op, s_busy, s_done;
  logic [2:0]  s_ra1, s_ra2, s_wa1, s_wa2;
  logic [1:0]  s_w;
  logic [31:0] s_wd1;

  logic        o_in_stall, o_bv, o_we1, o_we2, o_wb, o_op, o_busy, o_done;
  logic [3:0]  o_ra1, o_ra2, o_wa1, o_wa2;
  logic [2:0]  o_w;
  logic [31:0] o_wd1;

  fft_ctrl_sm_param #(.LOG2N(4), .DW(16), .BF_LAT(2)) dut (
    .clk(clk), .reset(reset), .in_push(in_push & ~sel), .in_real(in_real), .in_imag(in_imag),
    .in_stall(b_in_stall), .read_addr_1(b_ra1), .read_addr_2(b_ra2), .w_addr(b_w),
    .bfly_valid(b_bv), .write_addr_1(b_wa1), .write_data_1(b_wd1), .write_en_1(b_we1),
    .write_addr_2(b_wa2), .write_en_2(b_we2), .write_back(b_wb), .out_push(b_op),
    .out_stall(out_stall & ~sel), .busy(b_busy), .done(b_done));

  fft_ctrl_sm_param #(.LOG2N(3), .DW(16), .BF_LAT(1)) dut_s (
    .clk(clk), .reset(reset), .in_push(in_push & sel), .in_real(in_real), .in_imag(in_imag),
    .in_stall(s_in_stall), .read_addr_1(s_ra1), .read_addr_2(s_ra2), .w_addr(s_w),
    .bfly_valid(s_bv), .write_addr_1(s_wa1), .write_data_1(s_wd1), .write_en_1(s_we1),
    .write_addr_2(s_wa2), .write_en_2(s_we2), .write_back(s_wb), .out_push(s_op),
    .out_stall(out_stall & sel), .busy(s_busy), .done(s_done));

  assign o_in_stall = sel ? s_in_stall : b_in_stall;
  assign o_bv       = sel ? s_bv : b_bv;
  assign o_we1      = sel ? s_we1 : b_we1;
  assign o_we2      = sel ? s_we2 : b_we2;
  assign o_wb       = sel ? s_wb : b_wb;
  assign o_op       = sel ? s_op : b_op;
  assign o_busy     = sel ? s_busy : b_busy;
  assign o_done     = sel ? s_done : b_done;
  assign o_ra1      = sel ? {1'b0, s_ra1} : b_ra1;
  assign o_ra2      = sel ? {1'b0, s_ra2} : b_ra2;
  assign o_wa1      = sel ? {1'b0, s_wa1} : b_wa1;
  assign o_wa2      = sel ? {1'b0, s_wa2} : b_wa2;
  assign o_w        = sel ? {1'b0, s_w} : b_w;
  assign o_wd1      = sel ? s_wd1 : b_wd1;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     cyc;
    longint a;
    longint b;
    int     w;
  } ev_t;

  ev_t q_ld[$], q_iss[$], q_wr[$], q_out[$];
  int  n_chk = 0, n_err = 0;
  int  lg, lat, done_cnt, out_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int brev(input int v, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic to_cycle(input int t);
    if (cyc > t) chk("schedule", cyc, t);
    while (cyc < t) to_next();
  endtask

  task automatic flush();
    q_ld.delete();
    q_iss.delete();
    q_wr.delete();
    q_out.delete();
  endtask

  // Scoreboard pop side: every DUT-produced event must match the head of its queue.
  always @(negedge clk) begin
    ev_t e;
    if (o_we1 && !o_wb) begin
      if (q_ld.size() == 0) chk("ld_unexpected", 1, 0);
      else begin
        e = q_ld.pop_front();
        chk("ld_cyc", cyc, e.cyc);
        chk("ld_addr", o_wa1, e.a);
        chk("ld_data", o_wd1, e.b);
        chk("ld_stall", o_in_stall, 0);
      end
    end
    if (o_bv) begin
      if (q_iss.size() == 0) chk("iss_unexpected", 1, 0);
      else begin
        e = q_iss.pop_front();
        chk("iss_cyc", cyc, e.cyc);
        chk("iss_ra1", o_ra1, e.a);
        chk("iss_ra2", o_ra2, e.b);
        chk("iss_w", o_w, e.w);
        chk("iss_stall", o_in_stall, 1);
      end
    end
    if (o_wb && (o_we1 || o_we2)) begin
      if (q_wr.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        e = q_wr.pop_front();
        chk("wr_cyc", cyc, e.cyc);
        chk("wr_addr1", o_wa1, e.a);
        chk("wr_addr2", o_wa2, e.b);
        chk("wr_en_pair", {o_we1, o_we2}, 2'b11);
      end
    end
    if (o_op) begin
      out_cnt++;
      if (q_out.size() == 0) chk("out_unexpected", 1, 0);
      else begin
        e = q_out.pop_front();
        chk("out_cyc", cyc, e.cyc);
        chk("out_addr", o_ra1, e.a);
        chk("out_done", o_done, (e.a == (1 << lg) - 1));
      end
    end
    if (o_done) done_cnt++;
  end

  task automatic load_frame(input int ns, output int c_last);
    c_last = cyc;
    for (int k = 0; k < ns; k++) begin
      to_next();
      in_push = 1'b1;
      in_real = 16'(k * 3 + 1);
      in_imag = 16'(100 + k);
      q_ld.push_back('{cyc, brev(k, lg), {in_real, in_imag}, 0});
      c_last = cyc;
    end
    to_next();
    in_push = 1'b0;
  endtask

  // Reference addressing: group-major walk over blocks of 2*span.
  task automatic exp_compute(input int c);
    int n = 1 << lg;
    int h = n / 2;
    for (int s = 0; s < lg; s++) begin
      int span = 1 << s;
      int idx = 0;
      for (int g = 0; g < n; g += 2 * span) begin
        for (int j = 0; j < span; j++) begin
          int t = c + 1 + s * (h + lat) + idx;
          q_iss.push_back('{t, g + j, g + j + span, j * (h / span)});
          q_wr.push_back('{t + lat, g + j, g + j + span, 0});
          idx++;
        end
      end
    end
  endtask

  task automatic run_output(input int c, input int lo, input int hi);
    int n = 1 << lg;
    int start = c + 1 + lg * (n / 2 + lat);
    int addr = 0;
    int rel = 0;
    done_cnt = 0;
    out_cnt = 0;
    to_cycle(start - 1);
    chk("pre_out_push", o_op, 0);
    chk("pre_out_busy", o_busy, 1);
    while (addr < n && rel < n + 16) begin
      to_cycle(start + rel);
      out_stall = (rel >= lo && rel <= hi);
      #1;
      if (out_stall) begin
        chk("stall_push", o_op, 0);
        chk("stall_addr", o_ra1, addr);
      end else begin
        q_out.push_back('{cyc, addr, 0, 0});
        chk("out_push", o_op, 1);
        addr++;
      end
      rel++;
    end
    to_next();
    out_stall = 1'b0;
    #1;
    chk("post_busy", o_busy, 0);
    chk("post_in_stall", o_in_stall, 0);
    chk("done_count", done_cnt, 1);
    chk("out_count", out_cnt, n);
    chk("queues_empty", q_out.size() + q_iss.size() + q_wr.size() + q_ld.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, i_last, h;
    reset = 1'b1; in_push = 1'b0; out_stall = 1'b0; sel = 1'b0;
    in_real = '0; in_imag = '0; lg = 4; lat = 2;
    repeat (2) to_next();
    chk("rst_busy", o_busy, 0);
    chk("rst_in_stall", o_in_stall, 0);
    chk("rst_we", {o_we1, o_we2}, 0);
    chk("rst_bv", o_bv, 0);
    chk("rst_out", {o_op, o_done}, 0);
    chk("rst_wb", o_wb, 0);
    chk("rst_ra1", o_ra1, 0);
    reset = 1'b0;

    load_frame(5, c);
    chk("midload_busy", o_busy, 1);
    reset = 1'b1;
    #1;
    chk("midload_rst_busy", o_busy, 0);
    to_next();
    reset = 1'b0;

    load_frame(16, c);
    exp_compute(c);
    chk("compute_in_stall", o_in_stall, 1);
    chk("compute_busy", o_busy, 1);
    run_output(c, 3, 5);

    load_frame(16, c);
    exp_compute(c);
    h = 8;
    i_last = c + 1 + (lg - 1) * (h + lat) + h - 1;
    to_cycle(i_last + 1);
    flush();
    reset = 1'b1;
    #1;
    chk("late_rst_busy", o_busy, 0);
    chk("late_rst_in_stall", o_in_stall, 0);
    chk("late_rst_we", {o_we1, o_we2}, 0);
    to_next();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      to_next();
      chk("post_rst_we", {o_we1, o_we2}, 0);
      chk("post_rst_busy", o_busy, 0);
    end

    sel = 1'b1; lg = 3; lat = 1;
    reset = 1'b1;
    to_next();
    reset = 1'b0;
    load_frame(8, c);
    exp_compute(c);
    chk("small_in_stall", o_in_stall, 1);
    run_output(c, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
